// File: rtl/dlx_pkg.sv
// dlx_pkg: shared constants for the DLX execute stage.
//   WIDTH   - datapath width (only 32 is supported)
//   ALU_*   - ALUop encodings (5 bits)
//   S2_*    - s2op operand-B select/extension encodings (3 bits)
package dlx_pkg;

  localparam int WIDTH = 32;

  // ALUop encodings; every code not listed here is reserved and yields 0.
  localparam logic [4:0] ALU_ADD   = 5'b00000;
  localparam logic [4:0] ALU_SUB   = 5'b00001;
  localparam logic [4:0] ALU_AND   = 5'b00010;
  localparam logic [4:0] ALU_OR    = 5'b00011;
  localparam logic [4:0] ALU_XOR   = 5'b00100;
  localparam logic [4:0] ALU_SLL   = 5'b00101;
  localparam logic [4:0] ALU_SRL   = 5'b00110;
  localparam logic [4:0] ALU_SRA   = 5'b00111;
  localparam logic [4:0] ALU_SEQ   = 5'b01000;
  localparam logic [4:0] ALU_SNE   = 5'b01001;
  localparam logic [4:0] ALU_SLT   = 5'b01010;
  localparam logic [4:0] ALU_SGT   = 5'b01011;
  localparam logic [4:0] ALU_SLE   = 5'b01100;
  localparam logic [4:0] ALU_SGE   = 5'b01101;
  localparam logic [4:0] ALU_SLTU  = 5'b01110;
  localparam logic [4:0] ALU_PASSB = 5'b01111;
  localparam logic [4:0] ALU_BEQ   = 5'b10000;
  localparam logic [4:0] ALU_BEQZ  = 5'b10001;
  localparam logic [4:0] ALU_BNEZ  = 5'b10010;

  // s2op operand-B select / extension encodings.
  localparam logic [2:0] S2_REG    = 3'b000;
  localparam logic [2:0] S2_ZERO   = 3'b001;
  localparam logic [2:0] S2_FOUR   = 3'b010;
  localparam logic [2:0] S2_SEXT16 = 3'b011;
  localparam logic [2:0] S2_ZEXT16 = 3'b100;
  localparam logic [2:0] S2_LHI    = 3'b101;
  localparam logic [2:0] S2_SEXT26 = 3'b110;
  localparam logic [2:0] S2_ONE    = 3'b111;

endpackage

// File: rtl/dlx_alu_opb_mux.sv
// dlx_alu_opb_mux: combinational operand-B select and immediate extension.
//   s2   in  [WIDTH-1:0]  raw operand B (rs2 or instruction immediate field)
//   s2op in  [2:0]        select / extension mode
//   b    out [WIDTH-1:0]  operand B as seen by the ALU core
module dlx_alu_opb_mux
  import dlx_pkg::*;
#(
  parameter int W = WIDTH
) (
  input  logic [W-1:0] s2,
  input  logic [2:0]   s2op,
  output logic [W-1:0] b
);

  always_comb begin
    // NOTE: default assignment first so no path through the case leaves b
    // unassigned, which would otherwise infer a latch.
    b = '0;
    case (s2op)
      S2_REG:    b = s2;
      S2_ZERO:   b = '0;
      S2_FOUR:   b = W'(4);
      S2_SEXT16: b = {{(W-16){s2[15]}}, s2[15:0]};
      S2_ZEXT16: b = {{(W-16){1'b0}}, s2[15:0]};
      S2_LHI:    b = {s2[15:0], 16'h0000};           // load-high immediate
      S2_SEXT26: b = {{(W-26){s2[25]}}, s2[25:0]};   // J-type offset
      S2_ONE:    b = W'(1);
      default:   b = '0;
    endcase
  end

endmodule

// File: rtl/dlx_alu.sv
// dlx_alu: DLX execute-stage ALU with registered result and zero flag.
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset (clears ALUout and Zflag)
//   s1     in   [31:0] operand A (rs1)
//   s2     in   [31:0] operand B raw source (rs2 or immediate)
//   ALUop  in   [4:0]  operation select
//   s2op   in   [2:0]  operand-B select / extension
//   ALUout out  [31:0] registered result, one cycle after the inputs
//   Zflag  out         registered, 1 when ALUout is zero
module dlx_alu
  import dlx_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] s1,
  input  logic [WIDTH-1:0] s2,
  input  logic [4:0]       ALUop,
  input  logic [2:0]       s2op,
  output logic [WIDTH-1:0] ALUout,
  output logic             Zflag
);

  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] res;
  logic [4:0]       shamt;

  dlx_alu_opb_mux #(.W(WIDTH)) u_opb_mux (
    .s2   (s2),
    .s2op (s2op),
    .b    (b)
  );

  // Only the low five bits shift, so a shift by 32 wraps to a shift by 0.
  assign shamt = b[4:0];

  always_comb begin
    res = '0;
    case (ALUop)
      ALU_ADD:   res = s1 + b;
      ALU_SUB:   res = s1 - b;
      ALU_AND:   res = s1 & b;
      ALU_OR:    res = s1 | b;
      ALU_XOR:   res = s1 ^ b;
      ALU_SLL:   res = s1 << shamt;
      ALU_SRL:   res = s1 >> shamt;
      ALU_SRA:   res = $unsigned($signed(s1) >>> shamt);
      ALU_SEQ:   res = WIDTH'(s1 == b);
      ALU_SNE:   res = WIDTH'(s1 != b);
      ALU_SLT:   res = WIDTH'($signed(s1) <  $signed(b));
      ALU_SGT:   res = WIDTH'($signed(s1) >  $signed(b));
      ALU_SLE:   res = WIDTH'($signed(s1) <= $signed(b));
      ALU_SGE:   res = WIDTH'($signed(s1) >= $signed(b));
      ALU_SLTU:  res = WIDTH'(s1 < b);
      ALU_PASSB: res = b;
      // Branch ops produce a value whose zero-ness is the branch decision.
      ALU_BEQ:   res = s1 - b;
      ALU_BEQZ:  res = s1;
      ALU_BNEZ:  res = s1;
      default:   res = '0;
    endcase
  end

  // Zflag comes from the same value being registered, never a separate compare.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ALUout <= '0;
      Zflag  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge
      // values, independent of statement order or other always_ff blocks.
      ALUout <= res;
      Zflag  <= (res == '0);
    end
  end

endmodule

// File: tb/tb_dlx_alu.sv
// tb_dlx_alu: directed self-checking bench for dlx_alu.
module tb_dlx_alu;
  import dlx_pkg::*;

  logic        clk;
  logic        rst_n;
  logic [31:0] s1;
  logic [31:0] s2;
  logic [4:0]  ALUop;
  logic [2:0]  s2op;
  logic [31:0] ALUout;
  logic        Zflag;

  int checks   = 0;
  int failures = 0;

  dlx_alu #(.WIDTH(32)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .s1     (s1),
    .s2     (s2),
    .ALUop  (ALUop),
    .s2op   (s2op),
    .ALUout (ALUout),
    .Zflag  (Zflag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] actual,
                       input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Drive one operation away from the edge, clock it in, then check both
  // outputs; the expected Zflag is 1 exactly when the expected result is 0.
  task automatic run(input string tag, input logic [31:0] a,
                     input logic [31:0] bsrc, input logic [4:0] op,
                     input logic [2:0] sel, input logic [31:0] exp);
    @(negedge clk);
    s1    = a;
    s2    = bsrc;
    ALUop = op;
    s2op  = sel;
    @(posedge clk);
    #1;
    check({tag, ".out"}, ALUout, exp);
    check({tag, ".z"}, {31'd0, Zflag}, {31'd0, (exp == 32'd0)});
  endtask

  initial begin
    // Reset held across several edges with a live ADD 5+5 on the inputs.
    rst_n = 1'b0;
    s1    = 32'd5;
    s2    = 32'd5;
    ALUop = ALU_ADD;
    s2op  = S2_REG;
    repeat (3) @(posedge clk);
    #1;
    check("rst.out", ALUout, 32'd0);
    check("rst.z", {31'd0, Zflag}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_rel.out", ALUout, 32'd10);
    check("rst_rel.z", {31'd0, Zflag}, 32'd0);

    run("add",       32'd10,        32'd20,        ALU_ADD,   S2_REG,    32'd30);
    run("sub_zero0", 32'd0,         32'd0,         ALU_SUB,   S2_ZERO,   32'd0);
    run("sub_zero7", 32'd7,         32'd0,         ALU_SUB,   S2_ZERO,   32'd7);
    run("beq_eq",    32'd100,       32'd100,       ALU_BEQ,   S2_REG,    32'd0);
    run("beq_ne",    32'd100,       32'd99,        ALU_BEQ,   S2_REG,    32'd1);
    run("sra",       32'h8000_0000, 32'd4,         ALU_SRA,   S2_REG,    32'hF800_0000);
    run("srl",       32'h8000_0000, 32'd4,         ALU_SRL,   S2_REG,    32'h0800_0000);
    run("sra_by0",   32'h8000_0000, 32'd0,         ALU_SRA,   S2_REG,    32'h8000_0000);
    run("sll_31",    32'd1,         32'd31,        ALU_SLL,   S2_REG,    32'h8000_0000);
    run("sll_32",    32'h0000_1234, 32'd32,        ALU_SLL,   S2_REG,    32'h0000_1234);
    run("add_sext16",32'd0,         32'h0000_FFFF, ALU_ADD,   S2_SEXT16, 32'hFFFF_FFFF);
    run("add_zext16",32'd0,         32'hABCD_8000, ALU_ADD,   S2_ZEXT16, 32'h0000_8000);
    run("passb_lhi", 32'd0,         32'h0000_1234, ALU_PASSB, S2_LHI,    32'h1234_0000);
    run("add_sext26",32'd0,         32'h0200_0000, ALU_ADD,   S2_SEXT26, 32'hFE00_0000);
    run("add_four",  32'd100,       32'd0,         ALU_ADD,   S2_FOUR,   32'd104);
    run("add_one_wr",32'hFFFF_FFFF, 32'd0,         ALU_ADD,   S2_ONE,    32'd0);
    run("and",       32'hF0F0_F0F0, 32'hFF00_FF00, ALU_AND,   S2_REG,    32'hF000_F000);
    run("or",        32'hF0F0_F0F0, 32'hFF00_FF00, ALU_OR,    S2_REG,    32'hFFF0_FFF0);
    run("xor",       32'hF0F0_F0F0, 32'hFF00_FF00, ALU_XOR,   S2_REG,    32'h0FF0_0FF0);
    run("slt",       32'hFFFF_FFFF, 32'd1,         ALU_SLT,   S2_REG,    32'd1);
    run("sltu",      32'hFFFF_FFFF, 32'd1,         ALU_SLTU,  S2_REG,    32'd0);
    run("sgt",       32'hFFFF_FFFF, 32'd1,         ALU_SGT,   S2_REG,    32'd0);
    run("sle",       32'hFFFF_FFFF, 32'd1,         ALU_SLE,   S2_REG,    32'd1);
    run("sge",       32'd5,         32'd5,         ALU_SGE,   S2_REG,    32'd1);
    run("seq",       32'd3,         32'd3,         ALU_SEQ,   S2_REG,    32'd1);
    run("sne",       32'd3,         32'd3,         ALU_SNE,   S2_REG,    32'd0);
    run("beqz",      32'd0,         32'd9,         ALU_BEQZ,  S2_REG,    32'd0);
    run("bnez",      32'd5,         32'd9,         ALU_BNEZ,  S2_REG,    32'd5);
    run("rsvd_1f",   32'd5,         32'd5,         5'b11111,  S2_REG,    32'd0);
    run("rsvd_13",   32'd5,         32'd5,         5'b10011,  S2_REG,    32'd0);

    // Asynchronous reset between edges clears a nonzero registered result.
    run("pre_abort", 32'd1,         32'd1,         ALU_ADD,   S2_REG,    32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst.out", ALUout, 32'd0);
    check("async_rst.z", {31'd0, Zflag}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run("post_rst",  32'd2,         32'd3,         ALU_ADD,   S2_REG,    32'd5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dlx_alu.md
Name: dlx_alu

Overview:
- Execute-stage ALU for the non-pipelined DLX datapath.
- Applies the s2 operand-select mux, then performs the arithmetic, logic, shift, set-compare or branch-compare operation selected by ALUop.
- Result and zero flag are registered, giving one cycle of latency.
- Feeds the memory-address, writeback and branch-decision logic.

Parameters:
- WIDTH, 32, datapath width; only 32 is supported; shift amount is taken from bits [4:0].

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- s1  input  32  operand A (register rs1).
- s2  input  32  operand B raw source (register rs2 or instruction immediate field).
- ALUop  input  5  operation select.
- s2op  input  3  operand-B select / extension.
- ALUout  output  32  registered result.
- Zflag  output  1  registered flag, 1 when the registered ALUout equals 0.

Behaviour:
- rst_n low, asynchronously: ALUout = 0, Zflag = 0. Both are held until the first rising clk edge after rst_n deasserts.
- Every rising clk edge with rst_n high:
  - ALUout <= f(s1, b).
  - Zflag <= (f == 0).
  - There is no enable.
  - Latency is 1 cycle and throughput is 1 operation per cycle.
- Operand-B select b, driven by s2op:
  - 000: s2.
  - 001: constant 0.
  - 010: constant 4.
  - 011: sign-extended s2[15:0].
  - 100: zero-extended s2[15:0].
  - 101: {s2[15:0], 16'h0}.
  - 110: sign-extended s2[25:0].
  - 111: constant 1.
- ALUop encodings:
  - 00000 ADD: s1 + b.
  - 00001 SUB: s1 - b.
  - 00010 AND.
  - 00011 OR.
  - 00100 XOR.
  - 00101 SLL: s1 << b[4:0].
  - 00110 SRL: logical s1 >> b[4:0].
  - 00111 SRA: arithmetic s1 >>> b[4:0].
  - 01000 SEQ.
  - 01001 SNE.
  - 01010 SLT.
  - 01011 SGT.
  - 01100 SLE.
  - 01101 SGE.
  - 01110 SLTU.
  - 01111 PASSB: b.
  - 10000 BEQ: s1 - b, so Zflag = 1 when equal.
  - 10001 BEQZ: s1, so Zflag = 1 when s1 == 0.
  - 10010 BNEZ: s1, so Zflag = 1 when s1 == 0; branch logic inverts.
  - All other codes are reserved: result 0, so Zflag = 1.
- Arithmetic rules:
  - Modulo 2^32; carry and overflow are discarded; no exceptions.
  - Set-compares return 32'd1 or 32'd0.
  - SLT, SGT, SLE and SGE are signed two's complement; SLTU is unsigned.
- Shift boundaries:
  - Shift by 0 returns s1 unchanged.
  - Only b[4:0] is used, so a shift by 32 behaves as a shift by 0.
- Zflag is always derived from the same result that is registered into ALUout; it is never a separate compare.
- Reset asserted mid-operation aborts the pending result; outputs go to 0/0 immediately.
- X-free: every ALUop/s2op combination produces a defined value.

Decomposition:
- Package dlx_pkg holds:
  - ALUop localparams (ALU_ADD … ALU_BNEZ).
  - s2op localparams (S2_REG, S2_ZERO, S2_FOUR, S2_SEXT16, S2_ZEXT16, S2_LHI, S2_SEXT26, S2_ONE).
  - WIDTH.
- One sub-module, dlx_alu_opb_mux: combinational s2op operand-B select/extension.
- ALU core case statement and output register live in dlx_alu.

Test Plan:
- Reset: hold rst_n=0 with ALUop=ADD, s1=5, s2=5 and toggle clk → ALUout=0, Zflag=0. Release → the next edge gives ALUout=10, Zflag=0.
- ADD: s1=10, s2=20, ALUop=00000, s2op=000; one clk → ALUout=30, Zflag=0.
- SUB with operand select: s1=0, s2=0, ALUop=00001, s2op=001 → ALUout=0, Zflag=1. Same with s1=7 → ALUout=7, Zflag=0.
- BEQ: s1=100, s2=100, ALUop=10000, s2op=000 → ALUout=0, Zflag=1. Change s2 to 99 → ALUout=1, Zflag=0.
- Shifts/extension:
  - SRA, s1=0x80000000, s2=4 → 0xF8000000.
  - SRL, same operands → 0x08000000.
  - ADD with s2op=011, s1=0, s2=0x0000FFFF → 0xFFFFFFFF.
  - PASSB with s2op=101, s2=0x1234 → 0x12340000.
- Compares:
  - SLT, s1=0xFFFFFFFF, s2=1 → 1.
  - SLTU, same operands → 0.
  - SGE, s1=5, s2=5 → 1.
  - Reserved ALUop 11111 → ALUout=0, Zflag=1.
